multicycle_controller: RTL and testbench

Multi-cycle sequencer for the RV32I core datapath. It replaces per-instruction single-cycle control with a state machine that steps each instruction through fetch, decode, execute, memory and writeback. It handshakes with instruction and data memory, which may stall. It also detects illegal opcodes and memory timeouts, and counts retired instructions.

---
 rtl/ctrl_pkg.sv | 44 ++++
 rtl/instr_decode.sv | 29 ++
 rtl/multicycle_controller.sv | 187 ++++++++++++++++++
 tb/tb_multicycle_controller.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle sequencer: FSM states, instruction classes,
// opcode/funct3 constants, and ALU/immediate/fault-cause codes.
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_BRANCH, S_FAULT
  } state_t;

  typedef enum logic [2:0] {
    I_ADDI, I_ADD, I_SUB, I_LW, I_SW, I_BEQ, I_BNE, I_ILL
  } instr_t;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_W   = 3'b010;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;

  localparam logic [1:0] FC_NONE    = 2'b00;
  localparam logic [1:0] FC_ILLEGAL = 2'b01;
  localparam logic [1:0] FC_IMEM    = 2'b10;
  localparam logic [1:0] FC_DMEM    = 2'b11;

  function automatic logic is_mem(input instr_t i);
    return (i == I_LW) || (i == I_SW);
  endfunction

  function automatic logic is_branch(input instr_t i);
    return (i == I_BEQ) || (i == I_BNE);
  endfunction

endpackage

// File: rtl/instr_decode.sv
// Combinational instruction classifier: opcode/funct3/funct7[5] -> instruction class.
// Zero latency; no state, no flow control.
module instr_decode
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7_5_i,
  output instr_t     instr_o,
  output logic       illegal_o
);

  always_comb begin
    instr_o = I_ILL;
    case (opcode_i)
      OP_IMM:    if (funct3_i == F3_ADD) instr_o = I_ADDI;
      OP_REG:    if (funct3_i == F3_ADD) instr_o = funct7_5_i ? I_SUB : I_ADD;
      OP_LOAD:   if (funct3_i == F3_W)   instr_o = I_LW;
      OP_STORE:  if (funct3_i == F3_W)   instr_o = I_SW;
      OP_BRANCH: begin
        if (funct3_i == F3_BEQ)      instr_o = I_BEQ;
        else if (funct3_i == F3_BNE) instr_o = I_BNE;
      end
      default:   instr_o = I_ILL;
    endcase
    illegal_o = (instr_o == I_ILL);
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB/BRANCH, 3-5 cycles per instruction at zero wait.
// Memory stalls hold the req until ack; a wait of MEM_TIMEOUT cycles without ack parks the FSM in FAULT.
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0]           opcode,
  input  logic [2:0]           funct3,
  input  logic                 funct7_5,
  input  logic                 zero,
  input  logic                 imem_ack,
  input  logic                 dmem_ack,
  output logic                 imem_req,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic                 IRWrite,
  output logic                 PCWrite,
  output logic                 PCsrc,
  output logic                 RegWrite,
  output logic                 RegWriteSrc,
  output logic                 ALUsrc,
  output logic [2:0]           ALUctrl,
  output logic [1:0]           ImmSrc,
  output logic                 fault,
  output logic [1:0]           fault_cause,
  output logic [CNT_WIDTH-1:0] retired
);

  localparam int WW = $clog2(MEM_TIMEOUT);

  state_t                 state_q, state_d;
  instr_t                 instr_q, instr_d;
  logic [WW-1:0]          wait_q, wait_d;
  logic [CNT_WIDTH-1:0]   retired_q, retired_d;
  logic [1:0]             cause_q, cause_d;

  instr_t dec_instr;
  logic   dec_illegal;
  logic   wait_hit;
  logic   retire;
  logic   taken;

  instr_decode u_decode (
    .opcode_i   (opcode),
    .funct3_i   (funct3),
    .funct7_5_i (funct7_5),
    .instr_o    (dec_instr),
    .illegal_o  (dec_illegal)
  );

  assign wait_hit = (wait_q == WW'(MEM_TIMEOUT - 1));
  assign taken    = ((instr_q == I_BEQ) && zero) || ((instr_q == I_BNE) && !zero);

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    wait_d  = wait_q;
    cause_d = cause_q;
    retire  = 1'b0;
    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
        wait_d  = '0;
      end
      S_FETCH: begin
        // A same-cycle ack beats the timeout.
        if (imem_ack) begin
          state_d = S_DECODE;
        end else if (wait_hit) begin
          state_d = S_FAULT;
          cause_d = FC_IMEM;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      S_DECODE: begin
        instr_d = dec_instr;
        if (dec_illegal) begin
          state_d = S_FAULT;
          cause_d = FC_ILLEGAL;
        end else if (is_branch(dec_instr)) begin
          state_d = S_BRANCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_mem(instr_q)) begin
          state_d = S_MEM;
          wait_d  = '0;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (dmem_ack) begin
          if (instr_q == I_LW) begin
            state_d = S_WB;
          end else begin
            retire  = 1'b1;
            state_d = S_FETCH;
            wait_d  = '0;
          end
        end else if (wait_hit) begin
          state_d = S_FAULT;
          cause_d = FC_DMEM;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      S_WB, S_BRANCH: begin
        retire  = 1'b1;
        state_d = S_FETCH;
        wait_d  = '0;
      end
      default: state_d = S_FAULT;
    endcase
    retired_d = retire ? retired_q + CNT_WIDTH'(1) : retired_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      instr_q   <= I_ILL;
      wait_q    <= '0;
      retired_q <= '0;
      cause_q   <= FC_NONE;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
      cause_q   <= cause_d;
    end
  end

  // Outputs decode from registered state so a reset drops them immediately.
  always_comb begin
    imem_req    = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    IRWrite     = 1'b0;
    PCWrite     = 1'b0;
    PCsrc       = 1'b0;
    RegWrite    = 1'b0;
    RegWriteSrc = 1'b0;
    ALUsrc      = 1'b0;
    ALUctrl     = ALU_ADD;
    ImmSrc      = IMM_I;
    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        IRWrite  = imem_ack;
        PCWrite  = imem_ack;
      end
      S_EXEC, S_MEM, S_WB: begin
        ALUctrl = (instr_q == I_SUB) ? ALU_SUB : ALU_ADD;
        ALUsrc  = (instr_q == I_ADDI) || is_mem(instr_q);
        ImmSrc  = (instr_q == I_SW) ? IMM_S : IMM_I;
        if (state_q == S_MEM) begin
          dmem_req = 1'b1;
          dmem_we  = (instr_q == I_SW);
        end
        if (state_q == S_WB) begin
          RegWrite    = 1'b1;
          RegWriteSrc = (instr_q == I_LW);
        end
      end
      S_BRANCH: begin
        ALUctrl = ALU_SUB;
        ImmSrc  = IMM_B;
        PCWrite = taken;
        PCsrc   = taken;
      end
      default: ;
    endcase
  end

  assign fault       = (state_q == S_FAULT);
  assign fault_cause = cause_q;
  assign retired     = retired_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: cycle-by-cycle vector table plus hand-written
// sequences for fault, timeout, counter wrap and mid-instruction reset.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic       funct7_5 = 1'b0;
  logic       zero = 1'b0;
  logic       imem_ack = 1'b0;
  logic       dmem_ack = 1'b0;

  logic       imem_req, dmem_req, dmem_we, IRWrite, PCWrite, PCsrc;
  logic       RegWrite, RegWriteSrc, ALUsrc, fault;
  logic [2:0] ALUctrl;
  logic [1:0] ImmSrc, fault_cause;
  logic [2:0] retired;

  multicycle_controller #(.MEM_TIMEOUT(4), .CNT_WIDTH(3)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .zero(zero), .imem_ack(imem_ack), .dmem_ack(dmem_ack), .imem_req(imem_req),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .PCsrc(PCsrc), .RegWrite(RegWrite), .RegWriteSrc(RegWriteSrc), .ALUsrc(ALUsrc),
    .ALUctrl(ALUctrl), .ImmSrc(ImmSrc), .fault(fault), .fault_cause(fault_cause),
    .retired(retired)
  );

  always #5 clk = ~clk;

  logic [16:0] act_ctl;
  assign act_ctl = {imem_req, dmem_req, dmem_we, IRWrite, PCWrite, PCsrc, RegWrite,
                    RegWriteSrc, ALUsrc, ALUctrl, ImmSrc, fault, fault_cause};

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic        z;
    logic        ia;
    logic        da;
    logic [16:0] ctl;
    logic [2:0]  ret;
  } vec_t;

  vec_t tv[$];

  function automatic logic [16:0] E(input logic im, dm, we, irw, pcw, pcs, rw, rws, asrc,
                                    input logic [2:0] actl, input logic [1:0] isrc,
                                    input logic flt, input logic [1:0] fc);
    return {im, dm, we, irw, pcw, pcs, rw, rws, asrc, actl, isrc, flt, fc};
  endfunction

  function automatic vec_t V(input logic [6:0] op, input logic [2:0] f3, input logic f7, z,
                             ia, da, input logic [16:0] ctl, input logic [2:0] ret);
    vec_t v;
    v.op = op; v.f3 = f3; v.f7 = f7; v.z = z; v.ia = ia; v.da = da; v.ctl = ctl; v.ret = ret;
    return v;
  endfunction

  task automatic chk_ctl(input string name, input logic [16:0] exp);
    n_tests++;
    if (act_ctl !== exp) begin
      n_fail++;
      $display("FAIL %s: controls got %05h expected %05h", name, act_ctl, exp);
    end
  endtask

  task automatic chk_ret(input string name, input logic [2:0] exp);
    n_tests++;
    if (retired !== exp) begin
      n_fail++;
      $display("FAIL %s: retired got %0d expected %0d", name, retired, exp);
    end
  endtask

  // One clock: drive after the posedge, check at the negedge, advance to just past the next posedge.
  task automatic cyc(input string name, input logic [6:0] op, input logic [2:0] f3,
                     input logic f7, z, ia, da, input logic [16:0] ctl, input logic [2:0] ret);
    opcode = op; funct3 = f3; funct7_5 = f7; zero = z; imem_ack = ia; dmem_ack = da;
    @(negedge clk);
    chk_ctl(name, ctl);
    chk_ret({name, ".ret"}, ret);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string name);
    rst_n = 1'b0;
    opcode = '0; funct3 = '0; funct7_5 = 1'b0; zero = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    @(posedge clk);
    #1;
    chk_ctl({name, ".rst_ctl"}, 17'h0);
    chk_ret({name, ".rst_ret"}, 3'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  logic [6:0]  OPI, OPR, OPL, OPS, OPB, OPX;
  logic [16:0] c0, cFA, cFW, cEXaddi, cWBaddi, cWBadd, cEXsub, cWBsub, cEXlw, cMEMlw, cWBlw;
  logic [16:0] cEXsw, cMEMsw, cBRt, cBRn, cF1, cF2, cF3;

  initial begin
    OPI = 7'b0010011; OPR = 7'b0110011; OPL = 7'b0000011;
    OPS = 7'b0100011; OPB = 7'b1100011; OPX = 7'h7F;

    c0      = 17'h0;
    cFA     = E(1,0,0,1,1,0,0,0,0,3'b000,2'b00,0,2'b00);
    cFW     = E(1,0,0,0,0,0,0,0,0,3'b000,2'b00,0,2'b00);
    cEXaddi = E(0,0,0,0,0,0,0,0,1,3'b000,2'b00,0,2'b00);
    cWBaddi = E(0,0,0,0,0,0,1,0,1,3'b000,2'b00,0,2'b00);
    cWBadd  = E(0,0,0,0,0,0,1,0,0,3'b000,2'b00,0,2'b00);
    cEXsub  = E(0,0,0,0,0,0,0,0,0,3'b001,2'b00,0,2'b00);
    cWBsub  = E(0,0,0,0,0,0,1,0,0,3'b001,2'b00,0,2'b00);
    cEXlw   = E(0,0,0,0,0,0,0,0,1,3'b000,2'b00,0,2'b00);
    cMEMlw  = E(0,1,0,0,0,0,0,0,1,3'b000,2'b00,0,2'b00);
    cWBlw   = E(0,0,0,0,0,0,1,1,1,3'b000,2'b00,0,2'b00);
    cEXsw   = E(0,0,0,0,0,0,0,0,1,3'b000,2'b01,0,2'b00);
    cMEMsw  = E(0,1,1,0,0,0,0,0,1,3'b000,2'b01,0,2'b00);
    cBRt    = E(0,0,0,0,1,1,0,0,0,3'b001,2'b10,0,2'b00);
    cBRn    = E(0,0,0,0,0,0,0,0,0,3'b001,2'b10,0,2'b00);
    cF1     = E(0,0,0,0,0,0,0,0,0,3'b000,2'b00,1,2'b01);
    cF2     = E(0,0,0,0,0,0,0,0,0,3'b000,2'b00,1,2'b10);
    cF3     = E(0,0,0,0,0,0,0,0,0,3'b000,2'b00,1,2'b11);

    // ADDI, zero-wait: IDLE FETCH DECODE EXEC WB
    tv.push_back(V(OPI,3'b000,0,0,1,1,c0,     0));
    tv.push_back(V(OPI,3'b000,0,0,1,1,cFA,    0));
    tv.push_back(V(OPI,3'b000,0,0,1,1,c0,     0));
    tv.push_back(V(OPI,3'b000,0,0,1,1,cEXaddi,0));
    tv.push_back(V(OPI,3'b000,0,0,1,1,cWBaddi,0));
    // ADD
    tv.push_back(V(OPR,3'b000,0,0,1,1,cFA,    1));
    tv.push_back(V(OPR,3'b000,0,0,1,1,c0,     1));
    tv.push_back(V(OPR,3'b000,0,0,1,1,c0,     1));
    tv.push_back(V(OPR,3'b000,0,0,1,1,cWBadd, 1));
    // SUB
    tv.push_back(V(OPR,3'b000,1,0,1,1,cFA,    2));
    tv.push_back(V(OPR,3'b000,1,0,1,1,c0,     2));
    tv.push_back(V(OPR,3'b000,1,0,1,1,cEXsub, 2));
    tv.push_back(V(OPR,3'b000,1,0,1,1,cWBsub, 2));
    // LW, dmem_ack delayed 3 cycles: 8 cycles total
    tv.push_back(V(OPL,3'b010,0,0,1,0,cFA,    3));
    tv.push_back(V(OPL,3'b010,0,0,1,0,c0,     3));
    tv.push_back(V(OPL,3'b010,0,0,1,0,cEXlw,  3));
    tv.push_back(V(OPL,3'b010,0,0,1,0,cMEMlw, 3));
    tv.push_back(V(OPL,3'b010,0,0,1,0,cMEMlw, 3));
    tv.push_back(V(OPL,3'b010,0,0,1,0,cMEMlw, 3));
    tv.push_back(V(OPL,3'b010,0,0,1,1,cMEMlw, 3));
    tv.push_back(V(OPL,3'b010,0,0,1,1,cWBlw,  3));
    // SW retires from MEM
    tv.push_back(V(OPS,3'b010,0,0,1,1,cFA,    4));
    tv.push_back(V(OPS,3'b010,0,0,1,1,c0,     4));
    tv.push_back(V(OPS,3'b010,0,0,1,1,cEXsw,  4));
    tv.push_back(V(OPS,3'b010,0,0,1,1,cMEMsw, 4));
    // BNE zero=0 taken; BEQ zero=0 not taken; BEQ zero=1 taken
    tv.push_back(V(OPB,3'b001,0,0,1,1,cFA,    5));
    tv.push_back(V(OPB,3'b001,0,0,1,1,c0,     5));
    tv.push_back(V(OPB,3'b001,0,0,1,1,cBRt,   5));
    tv.push_back(V(OPB,3'b000,0,0,1,1,cFA,    6));
    tv.push_back(V(OPB,3'b000,0,0,1,1,c0,     6));
    tv.push_back(V(OPB,3'b000,0,0,1,1,cBRn,   6));
    tv.push_back(V(OPB,3'b000,0,1,1,1,cFA,    7));
    tv.push_back(V(OPB,3'b000,0,1,1,1,c0,     7));
    tv.push_back(V(OPB,3'b000,0,1,1,1,cBRt,   7));
    // retired wrapped to 0; imem ack on the 4th (last allowed) request cycle wins over timeout
    tv.push_back(V(OPR,3'b000,0,0,0,1,cFW,    0));
    tv.push_back(V(OPR,3'b000,0,0,0,1,cFW,    0));
    tv.push_back(V(OPR,3'b000,0,0,0,1,cFW,    0));
    tv.push_back(V(OPR,3'b000,0,0,1,1,cFA,    0));
    tv.push_back(V(OPR,3'b000,0,0,1,1,c0,     0));
    tv.push_back(V(OPR,3'b000,0,0,1,1,c0,     0));
    tv.push_back(V(OPR,3'b000,0,0,1,1,cWBadd, 0));
    tv.push_back(V(OPR,3'b000,0,0,1,1,cFA,    1));

    do_reset("init");
    for (int i = 0; i < tv.size(); i++)
      cyc($sformatf("tv%0d", i), tv[i].op, tv[i].f3, tv[i].f7, tv[i].z, tv[i].ia, tv[i].da,
          tv[i].ctl, tv[i].ret);

    // Illegal opcode: FAULT with cause 01, held for 20 cycles until reset
    do_reset("ill");
    cyc("ill.idle",  OPX, 3'b000, 0, 0, 1, 1, c0,  0);
    cyc("ill.fetch", OPX, 3'b000, 0, 0, 1, 1, cFA, 0);
    cyc("ill.dec",   OPX, 3'b000, 0, 0, 1, 1, c0,  0);
    for (int k = 0; k < 20; k++)
      cyc($sformatf("ill.hold%0d", k), OPX, 3'b000, 0, 0, 1, 1, cF1, 0);
    do_reset("ill_exit");
    cyc("ill_exit.idle", OPI, 3'b000, 0, 0, 1, 1, c0, 0);

    // imem timeout: 4 unacked request cycles then FAULT cause 10
    do_reset("itmo");
    cyc("itmo.idle", OPI, 3'b000, 0, 0, 0, 0, c0, 0);
    for (int k = 0; k < 4; k++)
      cyc($sformatf("itmo.req%0d", k), OPI, 3'b000, 0, 0, 0, 0, cFW, 0);
    cyc("itmo.fault0", OPI, 3'b000, 0, 0, 1, 1, cF2, 0);
    cyc("itmo.fault1", OPI, 3'b000, 0, 0, 1, 1, cF2, 0);

    // dmem timeout on LW: no RegWrite, FAULT cause 11
    do_reset("dtmo");
    cyc("dtmo.idle",  OPL, 3'b010, 0, 0, 1, 0, c0,    0);
    cyc("dtmo.fetch", OPL, 3'b010, 0, 0, 1, 0, cFA,   0);
    cyc("dtmo.dec",   OPL, 3'b010, 0, 0, 1, 0, c0,    0);
    cyc("dtmo.exec",  OPL, 3'b010, 0, 0, 1, 0, cEXlw, 0);
    for (int k = 0; k < 4; k++)
      cyc($sformatf("dtmo.mem%0d", k), OPL, 3'b010, 0, 0, 1, 0, cMEMlw, 0);
    cyc("dtmo.fault", OPL, 3'b010, 0, 0, 1, 1, cF3, 0);

    // Eight back-to-back ADDs wrap the 3-bit retired counter
    do_reset("wrap");
    cyc("wrap.idle", OPR, 3'b000, 0, 0, 1, 1, c0, 0);
    for (int k = 0; k < 8; k++) begin
      cyc($sformatf("wrap%0d.fetch", k), OPR, 3'b000, 0, 0, 1, 1, cFA,    3'(k));
      cyc($sformatf("wrap%0d.dec", k),   OPR, 3'b000, 0, 0, 1, 1, c0,     3'(k));
      cyc($sformatf("wrap%0d.exec", k),  OPR, 3'b000, 0, 0, 1, 1, c0,     3'(k));
      cyc($sformatf("wrap%0d.wb", k),    OPR, 3'b000, 0, 0, 1, 1, cWBadd, 3'(k));
    end
    cyc("wrap.end", OPR, 3'b000, 0, 0, 1, 1, cFA, 0);

    // Reset asserted mid-MEM drops dmem_req at once and clears retired
    do_reset("rmid");
    cyc("rmid.idle",  OPR, 3'b000, 0, 0, 1, 1, c0,     0);
    cyc("rmid.f0",    OPR, 3'b000, 0, 0, 1, 1, cFA,    0);
    cyc("rmid.d0",    OPR, 3'b000, 0, 0, 1, 1, c0,     0);
    cyc("rmid.e0",    OPR, 3'b000, 0, 0, 1, 1, c0,     0);
    cyc("rmid.w0",    OPR, 3'b000, 0, 0, 1, 1, cWBadd, 0);
    cyc("rmid.f1",    OPL, 3'b010, 0, 0, 1, 0, cFA,    1);
    cyc("rmid.d1",    OPL, 3'b010, 0, 0, 1, 0, c0,     1);
    cyc("rmid.e1",    OPL, 3'b010, 0, 0, 1, 0, cEXlw,  1);
    opcode = OPL; funct3 = 3'b010; imem_ack = 1'b1; dmem_ack = 1'b0;
    @(negedge clk);
    chk_ctl("rmid.mem", cMEMlw);
    chk_ret("rmid.mem.ret", 3'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_ctl("rmid.async_ctl", c0);
    chk_ret("rmid.async_ret", 3'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc("rmid.idle2", OPI, 3'b000, 0, 0, 1, 1, c0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
